// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: ID-stage hazard signals between the decode logic
// (master) and the hazard stall unit (slave).
interface hazard_stall_unit_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   id_ex_mem_read;
  logic [4:0]             id_ex_write_reg_addr;
  logic [4:0]             if_id_instr_rs;
  logic [4:0]             if_id_instr_rt;
  logic                   if_id_uses_rt;
  logic                   if_id_md_start;
  logic                   if_id_reads_hilo;
  logic                   branch_taken;
  logic                   pc_write;
  logic                   if_id_write;
  logic                   id_ex_flush;
  logic                   if_id_flush;
  logic                   md_busy;
  logic                   md_done;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output id_ex_mem_read, id_ex_write_reg_addr, if_id_instr_rs, if_id_instr_rt,
           if_id_uses_rt, if_id_md_start, if_id_reads_hilo, branch_taken,
    input  pc_write, if_id_write, id_ex_flush, if_id_flush, md_busy, md_done,
           stall_cycles
  );

  modport slave (
    input  id_ex_mem_read, id_ex_write_reg_addr, if_id_instr_rs, if_id_instr_rt,
           if_id_uses_rt, if_id_md_start, if_id_reads_hilo, branch_taken,
    output pc_write, if_id_write, id_ex_flush, if_id_flush, md_busy, md_done,
           stall_cycles
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: decode-stage load-use / mult-div hazard controller.
// Drives PC and IF/ID write enables and the ID/EX bubble, tracks the
// mult/div busy window and counts stalled cycles (saturating).
// Optional macro BRANCH_FLUSH_EN: squash the IF/ID instruction on a taken,
// unstalled branch; when undefined if_id_flush is tied low (delay slot).
//
// state | meaning
// IDLE  | mult/div unit free, a new issue may be accepted
// BUSY  | mult/div in progress, cnt counts down to the md_done cycle
module hazard_stall_unit #(
  parameter int MD_LATENCY  = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_unit_if.slave bus
);

  typedef enum logic {IDLE, BUSY} md_state_e;

  localparam logic [5:0] CNT_LOAD = 6'(MD_LATENCY - 1);

  md_state_e              state_q, state_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   busy;
  logic                   done;
  logic                   load_use;
  logic                   md_hazard;
  logic                   stall;

  // Hazard detection; everything is gated by rst_n so reset forces outputs.
  assign busy      = rst_n && (state_q == BUSY);
  assign load_use  = bus.id_ex_mem_read && (bus.id_ex_write_reg_addr != 5'd0) &&
                     ((bus.id_ex_write_reg_addr == bus.if_id_instr_rs) ||
                      (bus.if_id_uses_rt &&
                       (bus.id_ex_write_reg_addr == bus.if_id_instr_rt)));
  assign md_hazard = busy && (bus.if_id_md_start || bus.if_id_reads_hilo);
  assign stall     = rst_n && (load_use || md_hazard);

  // Pipeline register controls.
  assign bus.pc_write    = rst_n && !stall;
  assign bus.if_id_write = rst_n && !stall;
  assign bus.id_ex_flush = !rst_n || stall;
`ifdef BRANCH_FLUSH_EN
  assign bus.if_id_flush = rst_n && bus.branch_taken && !stall;
`else
  assign bus.if_id_flush = 1'b0;
`endif
  assign bus.md_busy      = busy;
  assign bus.md_done      = done;
  assign bus.stall_cycles = rst_n ? stall_cnt_q : '0;

  // Mult/div FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Mult/div next state; an issue is only accepted from IDLE when ID is not stalled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.if_id_md_start && !stall) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == 6'd0) begin
          done    = rst_n;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating stall-cycle counter: one count per stalled edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed bench, MD_LATENCY=4, STALL_CNT_W=4.
module tb_hazard_stall_unit;

  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total    = 0;
  logic exp_bflush;

  hazard_stall_unit_if #(.STALL_CNT_W(SW)) bus ();

  hazard_stall_unit #(.MD_LATENCY(4), .STALL_CNT_W(SW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.id_ex_mem_read       = 1'b0;
    bus.id_ex_write_reg_addr = 5'd0;
    bus.if_id_instr_rs       = 5'd0;
    bus.if_id_instr_rt       = 5'd0;
    bus.if_id_uses_rt        = 1'b0;
    bus.if_id_md_start       = 1'b0;
    bus.if_id_reads_hilo     = 1'b0;
    bus.branch_taken         = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] wr, input logic [4:0] rs);
    bus.id_ex_mem_read       = 1'b1;
    bus.id_ex_write_reg_addr = wr;
    bus.if_id_instr_rs       = rs;
  endtask

  initial begin
`ifdef BRANCH_FLUSH_EN
    exp_bflush = 1'b1;
`else
    exp_bflush = 1'b0;
`endif
    rst_n = 1'b0;
    clear_in();
    set_lu(5'd3, 5'd3);
    bus.branch_taken   = 1'b1;
    bus.if_id_md_start = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_pc_write", 32'(bus.pc_write), 32'd0);
    chk("rst_if_id_write", 32'(bus.if_id_write), 32'd0);
    chk("rst_id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
    chk("rst_if_id_flush", 32'(bus.if_id_flush), 32'd0);
    chk("rst_md_busy", 32'(bus.md_busy), 32'd0);
    chk("rst_md_done", 32'(bus.md_done), 32'd0);
    chk("rst_stall_cycles", 32'(bus.stall_cycles), 32'd0);

    rst_n = 1'b1;
    clear_in();
    #1;
    chk("idle_pc_write", 32'(bus.pc_write), 32'd1);
    chk("idle_id_ex_flush", 32'(bus.id_ex_flush), 32'd0);
    tick();

    // load-use on rs
    set_lu(5'd5, 5'd5);
    #1;
    chk("lu_rs_pc_write", 32'(bus.pc_write), 32'd0);
    chk("lu_rs_if_id_write", 32'(bus.if_id_write), 32'd0);
    chk("lu_rs_id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
    chk("lu_rs_cnt_before", 32'(bus.stall_cycles), 32'd0);
    tick();
    clear_in();
    #1;
    chk("lu_rs_cnt_after", 32'(bus.stall_cycles), 32'd1);
    chk("lu_rs_pc_write_after", 32'(bus.pc_write), 32'd1);
    chk("lu_rs_if_id_write_after", 32'(bus.if_id_write), 32'd1);
    chk("lu_rs_flush_after", 32'(bus.id_ex_flush), 32'd0);

    // $0 and rt filter
    set_lu(5'd0, 5'd0);
    #1;
    chk("lu_r0_no_stall", 32'(bus.pc_write), 32'd1);
    set_lu(5'd7, 5'd3);
    bus.if_id_instr_rt = 5'd7;
    #1;
    chk("lu_rt_unused_no_stall", 32'(bus.pc_write), 32'd1);
    bus.if_id_uses_rt = 1'b1;
    #1;
    chk("lu_rt_used_stall", 32'(bus.pc_write), 32'd0);
    chk("lu_rt_used_flush", 32'(bus.id_ex_flush), 32'd1);
    tick();
    clear_in();
    #1;
    chk("lu_rt_cnt", 32'(bus.stall_cycles), 32'd2);

    // taken branch, alone and with concurrent load-use
    bus.branch_taken = 1'b1;
    #1;
    chk("br_flush", 32'(bus.if_id_flush), 32'(exp_bflush));
    chk("br_no_stall", 32'(bus.pc_write), 32'd1);
    set_lu(5'd4, 5'd4);
    #1;
    chk("br_lu_flush", 32'(bus.if_id_flush), 32'd0);
    chk("br_lu_stall", 32'(bus.id_ex_flush), 32'd1);
    tick();
    clear_in();
    #1;
    chk("br_lu_cnt", 32'(bus.stall_cycles), 32'd3);

    // mult then mfhi; cycle 2 also carries a load-use (one count only)
    bus.if_id_md_start = 1'b1;
    #1;
    chk("md_issue_busy", 32'(bus.md_busy), 32'd0);
    chk("md_issue_pc_write", 32'(bus.pc_write), 32'd1);
    tick();
    clear_in();
    bus.if_id_reads_hilo = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) set_lu(5'd9, 5'd9);
      else begin
        bus.id_ex_mem_read = 1'b0;
      end
      #1;
      chk($sformatf("md_busy_c%0d", c), 32'(bus.md_busy), 32'd1);
      chk($sformatf("md_done_c%0d", c), 32'(bus.md_done), (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("mfhi_stall_c%0d", c), 32'(bus.pc_write), 32'd0);
      tick();
    end
    bus.id_ex_mem_read = 1'b0;
    #1;
    chk("md_c5_busy", 32'(bus.md_busy), 32'd0);
    chk("md_c5_done", 32'(bus.md_done), 32'd0);
    chk("mfhi_c5_advance", 32'(bus.pc_write), 32'd1);
    chk("md_c5_cnt", 32'(bus.stall_cycles), 32'd7);
    clear_in();
    tick();

    // reset during BUSY at cnt=2
    bus.if_id_md_start = 1'b1;
    tick();
    clear_in();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rstbusy_forced_busy", 32'(bus.md_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rstbusy_busy_after", 32'(bus.md_busy), 32'd0);
    chk("rstbusy_cnt", 32'(bus.stall_cycles), 32'd0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("rstbusy_no_done_%0d", c), 32'(bus.md_done), 32'd0);
      chk($sformatf("rstbusy_no_busy_%0d", c), 32'(bus.md_busy), 32'd0);
      tick();
    end

    // saturation of the 4-bit counter
    set_lu(5'd6, 5'd6);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("sat_%0d", i), 32'(bus.stall_cycles), (i > 15) ? 32'd15 : 32'(i));
    end
    clear_in();
    tick();
    chk("sat_hold", 32'(bus.stall_cycles), 32'd15);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

- Decode-stage hazard controller that covers the cases operand forwarding in EX cannot.
- Detects load-use dependencies and tracks the multi-cycle multiply/divide unit's busy window, then drives the PC/IF-ID write enables and the ID/EX bubble insert.
- Optionally squashes the fetched instruction on a taken branch, and keeps a saturating stall-cycle counter for performance analysis.
- Sits beside the ID stage and feeds the PC register, the IF/ID register and the ID/EX register control inputs.

## Interface
Parameters:
- MD_LATENCY, 32, cycles the mult/div unit stays busy after issue; legal range 2..63.
- STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_write_reg_addr  in  5  destination register of the EX instruction.
- if_id_instr_rs  in  5  rs field of the ID instruction.
- if_id_instr_rt  in  5  rt field of the ID instruction.
- if_id_uses_rt  in  1  ID instruction reads rt as a source.
- if_id_md_start  in  1  ID instruction is mult/multu/div/divu.
- if_id_reads_hilo  in  1  ID instruction is mfhi/mflo.
- branch_taken  in  1  branch in ID resolved taken this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- id_ex_flush  out  1  force ID/EX control fields to zero (bubble).
- if_id_flush  out  1  clear IF/ID to a NOP.
- md_busy  out  1  mult/div unit occupied.
- md_done  out  1  one-cycle pulse: HI/LO written at end of this cycle.
- stall_cycles  out  STALL_CNT_W  saturating count of stalled cycles.

## Operation
- load_use = id_ex_mem_read && id_ex_write_reg_addr != 0 && (id_ex_write_reg_addr == if_id_instr_rs || (if_id_uses_rt && id_ex_write_reg_addr == if_id_instr_rt)).
- md_hazard = md_busy && (if_id_md_start || if_id_reads_hilo).
- stall = load_use || md_hazard.
- When stall is high: pc_write=0, if_id_write=0, id_ex_flush=1.
- When stall is low: pc_write=1, if_id_write=1, id_ex_flush=0.
- Mult/div FSM has two states, IDLE and BUSY, with a 6-bit down-counter cnt.
  - IDLE: if if_id_md_start && !stall, go to BUSY next edge with cnt=MD_LATENCY-1.
  - BUSY: cnt decrements each cycle. When cnt==0, md_done=1 and the FSM returns to IDLE next edge.
  - md_busy=1 in every BUSY cycle, including the md_done cycle.
- An issue is accepted only from IDLE, because md_start in ID during BUSY stalls. Back-to-back mult/div therefore issue MD_LATENCY+1 cycles apart.
- A branch in ID that is stalled does not flush. if_id_flush = branch_taken && !stall, and the branch re-resolves once the stall clears.
- stall_cycles increments by 1 on each edge where stall==1, saturating at all-ones.
- While rst_n is low, all outputs are forced to their reset values regardless of inputs.

## Timing
- Reset (edge with rst_n=0): FSM=IDLE, cnt=0, stall_cycles=0.
- Output values while rst_n=0: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0, md_busy=0, md_done=0.
- Reset mid-BUSY aborts the operation: no md_done pulse, and md_busy=0 on the first cycle after rst_n rises.
- Output latency:
  - load_use, stall and flush outputs are combinational from inputs and current state, with zero-cycle latency.
  - md_busy and md_done depend only on state.
- Load-use costs exactly one stall cycle: after the bubble, the load moves to MEM and the forwarding unit supplies the data.
- mfhi issued in ID during the md_done cycle stalls that cycle and proceeds the next cycle.
- Simultaneous load_use and md_hazard produce one stall cycle for that cycle; stall_cycles increments by 1, not 2.

## Configuration
- BRANCH_FLUSH_EN defined: if_id_flush = branch_taken && !stall, which squashes the instruction after a taken branch.
- BRANCH_FLUSH_EN undefined: if_id_flush is constant 0, giving architectural MIPS delay-slot behaviour; branch_taken is ignored.

## Test plan
- Load-use on rs: lw to $5 in EX, ID reads rs=5 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1, stall_cycles 0->1; next cycle all enables are 1.
- $0 and rt filter:
  - lw to $0 with rs=0 -> no stall.
  - lw to $7 with rt=7 and if_id_uses_rt=0 -> no stall.
  - lw to $7 with rt=7 and if_id_uses_rt=1 -> stall.
- Mult then mfhi, MD_LATENCY=4: issue at cycle 0 -> md_busy in cycles 1-4, md_done in cycle 4, mfhi stalled in cycles 1-4 and advancing in cycle 5.
- Taken branch with BRANCH_FLUSH_EN:
  - branch_taken=1, stall=0 -> if_id_flush=1.
  - Same with concurrent load-use -> if_id_flush=0 and stall=1.
  - Same with macro undefined -> if_id_flush always 0.
- Reset during BUSY at cnt=2 -> md_busy=0 after release, no md_done pulse, stall_cycles=0.
- Saturation with STALL_CNT_W=4: 20 consecutive stall cycles -> stall_cycles holds 15.
